// File: rtl/port_out_fifo_bridge.sv
// Bridges a CPU output-port pair (data byte + strobe/control byte) into a
// first-word-fall-through FIFO with a valid/ready consumer interface.
// A status byte {ovf, full, empty, 0, count[3:0]} is returned for polling.
module port_out_fifo_bridge #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] wr_data,
    input  logic [7:0] wr_ctrl,
    output logic [7:0] status,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       ovf
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [1:0]    ctrl_prev_q;

    logic push_req, clr_req, pop, full, empty, do_push, overflow;
    logic [4:0] count_ext;

    assign push_req = wr_ctrl[0] & ~ctrl_prev_q[0];
    assign clr_req  = wr_ctrl[1] & ~ctrl_prev_q[1];
    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign pop      = ~empty & m_ready;
    // A push into a full FIFO is only accepted if a pop frees a slot this cycle.
    assign do_push  = push_req & (~full | pop);
    assign overflow = push_req & full & ~pop;

    // Next-state for pointers, fill count and sticky overflow.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        unique case ({do_push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        // Set wins over clear when both happen in one cycle.
        if (overflow) begin
            ovf_d = 1'b1;
        end else if (clr_req) begin
            ovf_d = 1'b0;
        end
    end

    // Control state register; ctrl_prev still tracks wr_ctrl during reset so a
    // strobe held across reset release does not look like a rising edge.
    always_ff @(posedge clk) begin
        ctrl_prev_q <= wr_ctrl[1:0];
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Outputs are driven only from registered state.
    always_comb begin
        count_ext = 5'(count_q);
        status    = {ovf_q, full, empty, 1'b0, count_ext[3:0]};
        m_data    = mem[rd_ptr_q];
        m_valid   = ~empty;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_port_out_fifo_bridge.sv
// Directed self-checking bench for port_out_fifo_bridge (DEPTH = 8).
module tb_port_out_fifo_bridge;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] wr_data;
    logic [7:0] wr_ctrl;
    logic [7:0] status;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    port_out_fifo_bridge #(
        .DEPTH (8),
        .AW    (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_data (wr_data),
        .wr_ctrl (wr_ctrl),
        .status  (status),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // Advance one clock edge, then step past it so outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Rising edge on the strobe for one cycle, then release.
    task automatic push(input logic [7:0] d);
        wr_data = d;
        wr_ctrl = 8'h01;
        tick();
        wr_ctrl = 8'h00;
        tick();
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] d);
        check({tag, "_valid"}, {7'd0, m_valid}, 8'h01);
        check(tag, m_data, d);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    initial begin
        // 1. Strobe held high across reset release: no push.
        reset   = 1'b1;
        wr_ctrl = 8'h01;
        wr_data = 8'h00;
        m_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("rst_status", status, 8'h20);
        check("rst_valid", {7'd0, m_valid}, 8'h00);
        check("rst_ovf", {7'd0, ovf}, 8'h00);

        // 2. Single push, visible one cycle later, no bypass.
        wr_ctrl = 8'h00;
        tick();
        wr_data = 8'h0E;
        wr_ctrl = 8'h01;
        m_ready = 1'b1;
        #1;
        check("no_bypass_valid", {7'd0, m_valid}, 8'h00);
        m_ready = 1'b0;
        tick();
        check("push1_valid", {7'd0, m_valid}, 8'h01);
        check("push1_data", m_data, 8'h0E);
        check("push1_status", status, 8'h01);
        tick();
        check("level_once_status", status, 8'h01);
        wr_ctrl = 8'h00;
        pop_expect("pop1", 8'h0E);
        check("pop1_status", status, 8'h20);

        // 3. Fill, overflow drop, drain in order.
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        check("full_status", status, 8'h48);
        check("full_head", m_data, 8'h10);
        push(8'hAA);
        check("ovf_status", status, 8'hC8);
        check("ovf_flag", {7'd0, ovf}, 8'h01);
        for (int i = 0; i < 8; i++) pop_expect("drain", 8'h10 + 8'(i));
        check("drained_status", status, 8'hA0);

        // 5a. Clear overflow via rising edge on bit1.
        wr_ctrl = 8'h02;
        tick();
        check("clr_ovf", {7'd0, ovf}, 8'h00);
        check("clr_status", status, 8'h20);
        wr_ctrl = 8'h00;
        tick();

        // 4. Push into full FIFO with a same-cycle pop.
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        check("refill_status", status, 8'h48);
        wr_data = 8'h99;
        wr_ctrl = 8'h01;
        m_ready = 1'b1;
        tick();
        wr_ctrl = 8'h00;
        m_ready = 1'b0;
        tick();
        check("pushpop_status", status, 8'h48);
        check("pushpop_ovf", {7'd0, ovf}, 8'h00);
        check("pushpop_head", m_data, 8'h11);

        // 5b. Overflow, then clear coinciding with a new overflow: set wins.
        push(8'hBB);
        check("ovf2_status", status, 8'hC8);
        wr_data = 8'hCC;
        wr_ctrl = 8'h03;
        tick();
        check("setwins_ovf", {7'd0, ovf}, 8'h01);
        check("setwins_status", status, 8'hC8);
        wr_ctrl = 8'h00;
        tick();
        wr_ctrl = 8'h02;
        tick();
        check("clr2_status", status, 8'h48);
        wr_ctrl = 8'h00;
        tick();
        for (int i = 1; i < 8; i++) pop_expect("drain2", 8'h10 + 8'(i));
        pop_expect("drain2_last", 8'h99);
        check("drain2_status", status, 8'h20);

        // 6. Reset mid-operation discards data and restarts pointers.
        push(8'h01);
        push(8'h02);
        push(8'h03);
        check("pre_rst_status", status, 8'h03);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_valid", {7'd0, m_valid}, 8'h00);
        check("midrst_status", status, 8'h20);
        tick();
        push(8'h55);
        push(8'h66);
        check("post_rst_status", status, 8'h02);
        pop_expect("post_rst_first", 8'h55);
        pop_expect("post_rst_second", 8'h66);
        check("post_rst_empty", status, 8'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
